// File: rtl/ddr_ctrl_aref.sv
// ============================================================================
// ddr_ctrl_aref
// ----------------------------------------------------------------------------
// Auto-refresh sequencer for the SDRAM controller.
//
// An interval counter runs while the SDRAM is initialized (init_end_i=1). It
// wraps every REF_PERIOD cycles, and each wrap raises a refresh request
// toward the arbiter. Once the arbiter grants the AREF path (aref_en_i), the
// FSM issues the refresh sequence:
//
//   PRECHARGE-ALL, NOP x TRP_CLK,
//   { AUTO_REFRESH, NOP x TRFC_CLK } x AREF_NUM,
//   NOP with aref_end_o=1 (1 cycle)
//
// The sequence is 2 + TRP_CLK + AREF_NUM*(1+TRFC_CLK) cycles long. Once it
// starts it always runs to completion, even if the grant or init_end_i drops.
//
// Parameters:
//   REF_PERIOD  refresh interval in sys_clk cycles (>= 32)
//   TRP_CLK     NOP cycles after PRECHARGE (1..15)
//   TRFC_CLK    NOP cycles after each AUTO_REFRESH (1..15)
//   AREF_NUM    AUTO_REFRESH commands per sequence (1..4)
//
// Ports:
//   sys_clk      in   system clock
//   sys_rst_n    in   asynchronous, active-low reset
//   init_end_i   in   SDRAM initialization finished (level)
//   aref_en_i    in   refresh grant from the arbiter (level)
//   aref_req_o   out  refresh request to the arbiter
//   aref_end_o   out  one-cycle pulse at the end of a refresh sequence
//   aref_cmd_o   out  SDRAM command {cs_n, ras_n, cas_n, we_n}
//   aref_ba_o    out  bank address (always 2'b11)
//   aref_addr_o  out  address bus (always 13'h1fff; A10=1 selects all banks)
//   aref_ovf_o   out  sticky missed-interval flag (DDR_AREF_OVF_EN only)
//
// Build option:
//   DDR_AREF_OVF_EN  when defined, adds aref_ovf_o. It is set when a
//                    refresh interval expires while the previous request is
//                    still pending or a sequence is still running. Only
//                    reset clears it.
// ============================================================================
module ddr_ctrl_aref #(
    parameter int REF_PERIOD = 1250,
    parameter int TRP_CLK    = 2,
    parameter int TRFC_CLK   = 7,
    parameter int AREF_NUM   = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end_i,
    input  logic        aref_en_i,
    output logic        aref_req_o,
    output logic        aref_end_o,
    output logic [3:0]  aref_cmd_o,
    output logic [1:0]  aref_ba_o,
    output logic [12:0] aref_addr_o
`ifdef DDR_AREF_OVF_EN
    ,
    output logic        aref_ovf_o
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CNT_W = $clog2(REF_PERIOD);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REF_PERIOD - 1);
    localparam logic [3:0]       TRP_LAST  = 4'(TRP_CLK - 1);
    localparam logic [3:0]       TRFC_LAST = 4'(TRFC_CLK - 1);
    localparam logic [2:0]       AR_TOTAL  = 3'(AREF_NUM);

    // SDRAM command encodings {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PCH  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PCH,
        S_TRP,
        S_AR,
        S_TRFC,
        S_END
    } state_t;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] ref_cnt;     // refresh interval counter
    logic             ref_tc;      // interval expires on this edge
    logic             seq_start;   // FSM leaves IDLE on this edge
    state_t           state;
    logic [3:0]       wait_cnt;    // NOP cycles spent in TRP / TRFC
    logic [2:0]       ar_cnt;      // AUTO_REFRESH commands issued so far

    // The counter is held at 0 while init_end_i is low, so it can only reach
    // its terminal count while init_end_i is high. The explicit gate keeps an
    // init_end_i drop on the terminal edge from posting a request.
    assign ref_tc = init_end_i && (ref_cnt == CNT_LAST);

    // A grant alone is not enough to start. The arbiter may still hold
    // aref_en_i in the cycle after aref_end_o; because aref_req_o is low
    // then, that lagging grant cannot restart the sequence.
    assign seq_start = (state == S_IDLE) && aref_req_o && aref_en_i && init_end_i;

    // Bank and address do not change: A10=1 selects all banks for PRECHARGE.
    // AUTO_REFRESH ignores them.
    assign aref_ba_o   = 2'b11;
    assign aref_addr_o = 13'h1fff;

    // ------------------------------------------------------------------------
    // Refresh interval counter
    // ------------------------------------------------------------------------
    // NOTE: every register in this file uses non-blocking assignments, so
    // all of them update together from the values present before the edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ref_cnt <= '0;
        end else if (!init_end_i) begin
            ref_cnt <= '0;
        end else if (ref_cnt == CNT_LAST) begin
            ref_cnt <= '0;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Refresh request
    // ------------------------------------------------------------------------
    // Leaving IDLE has priority. A terminal count on that edge finds the
    // request already high and is absorbed; requests are never queued.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            aref_req_o <= 1'b0;
        end else if (seq_start) begin
            aref_req_o <= 1'b0;
        end else if (ref_tc) begin
            aref_req_o <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Refresh sequencer
    // ------------------------------------------------------------------------
    // aref_cmd_o and aref_end_o are loaded in the same branch as the state
    // they belong to. They are therefore registered, and they always equal
    // the decode of the state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            ar_cnt     <= '0;
            aref_cmd_o <= CMD_NOP;
            aref_end_o <= 1'b0;
        end else begin
            // NOTE: these defaults are overridden only by the transitions
            // that enter PCH, AR or END. Every other edge therefore returns
            // the outputs to NOP with no end pulse, and pulses last exactly
            // one cycle.
            aref_cmd_o <= CMD_NOP;
            aref_end_o <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (seq_start) begin
                        state      <= S_PCH;
                        wait_cnt   <= '0;
                        aref_cmd_o <= CMD_PCH;
                    end
                end

                S_PCH: begin
                    state    <= S_TRP;
                    wait_cnt <= '0;
                end

                S_TRP: begin
                    if (wait_cnt == TRP_LAST) begin
                        state      <= S_AR;
                        wait_cnt   <= '0;
                        aref_cmd_o <= CMD_AREF;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_AR: begin
                    state    <= S_TRFC;
                    wait_cnt <= '0;
                    ar_cnt   <= ar_cnt + 1'b1;
                end

                S_TRFC: begin
                    if (wait_cnt == TRFC_LAST) begin
                        wait_cnt <= '0;
                        if (ar_cnt == AR_TOTAL) begin
                            state      <= S_END;
                            aref_end_o <= 1'b1;
                        end else begin
                            state      <= S_AR;
                            aref_cmd_o <= CMD_AREF;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_END: begin
                    state    <= S_IDLE;
                    wait_cnt <= '0;
                    ar_cnt   <= '0;
                end

                default: begin
                    state    <= S_IDLE;
                    wait_cnt <= '0;
                    ar_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef DDR_AREF_OVF_EN
    // ------------------------------------------------------------------------
    // Missed-interval flag
    // ------------------------------------------------------------------------
    // An interval expired while the previous refresh was still pending
    // (request high) or still running (FSM busy). Only reset clears it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            aref_ovf_o <= 1'b0;
        end else if (ref_tc && (aref_req_o || (state != S_IDLE))) begin
            aref_ovf_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr_ctrl_aref.sv
// ============================================================================
// tb_ddr_ctrl_aref
// ----------------------------------------------------------------------------
// Scoreboard bench for ddr_ctrl_aref. Two instances share clock, reset and
// init_end:
//   inst0: default parameters (1250 / 2 / 7 / 2)
//   inst1: short interval with a single refresh (40 / 2 / 3 / 1)
//
// On every rising edge, a reference model computes the expected outputs of
// both instances and pushes them into exp_q. The model is built from the
// refresh rules: an interval tick count, a pending-request bit, and a
// pre-built list of commands for the whole sequence. A monitor pops the
// queue 1 ns after the same edge and compares the values with the DUT pins.
// ============================================================================
module tb_ddr_ctrl_aref;

    localparam int NI = 2;
    localparam int P_REF  [NI] = '{1250, 40};
    localparam int P_TRP  [NI] = '{2, 2};
    localparam int P_TRFC [NI] = '{7, 3};
    localparam int P_NUM  [NI] = '{2, 1};

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PCH = 4'b0010;
    localparam logic [3:0] ARF = 4'b0001;

    typedef struct packed {
        logic        req;
        logic        end_p;
        logic        ovf;
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
    } obs_t;

    typedef enum int {M_HOLD, M_ARB, M_RAND} mode_t;

    // ------------------------------------------------------------------------
    // DUT wiring
    // ------------------------------------------------------------------------
    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        init_end  = 1'b0;
    logic        en0 = 1'b0, en1 = 1'b0;
    logic        req0, end0, req1, end1, ovf0, ovf1;
    logic [3:0]  cmd0, cmd1;
    logic [1:0]  ba0, ba1;
    logic [12:0] addr0, addr1;

    always #3 sys_clk = ~sys_clk;

    ddr_ctrl_aref #(
        .REF_PERIOD (1250),
        .TRP_CLK    (2),
        .TRFC_CLK   (7),
        .AREF_NUM   (2)
    ) u_dut0 (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .init_end_i  (init_end),
        .aref_en_i   (en0),
        .aref_req_o  (req0),
        .aref_end_o  (end0),
        .aref_cmd_o  (cmd0),
        .aref_ba_o   (ba0),
        .aref_addr_o (addr0)
`ifdef DDR_AREF_OVF_EN
        ,
        .aref_ovf_o  (ovf0)
`endif
    );

    ddr_ctrl_aref #(
        .REF_PERIOD (40),
        .TRP_CLK    (2),
        .TRFC_CLK   (3),
        .AREF_NUM   (1)
    ) u_dut1 (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .init_end_i  (init_end),
        .aref_en_i   (en1),
        .aref_req_o  (req1),
        .aref_end_o  (end1),
        .aref_cmd_o  (cmd1),
        .aref_ba_o   (ba1),
        .aref_addr_o (addr1)
`ifdef DDR_AREF_OVF_EN
        ,
        .aref_ovf_o  (ovf1)
`endif
    );

`ifndef DDR_AREF_OVF_EN
    assign ovf0 = 1'b0;
    assign ovf1 = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    obs_t exp_q[$];

    function automatic obs_t mk(logic r, logic e, logic o, logic [3:0] c);
        obs_t t;
        t.req   = r;
        t.end_p = e;
        t.ovf   = o;
        t.cmd   = c;
        t.ba    = 2'b11;
        t.addr  = 13'h1fff;
        return t;
    endfunction

    function automatic obs_t act(int i);
        if (i == 0) return {req0, end0, ovf0, cmd0, ba0, addr0};
        return {req1, end1, ovf1, cmd1, ba1, addr1};
    endfunction

    task automatic check(string name, obs_t a, obs_t e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got req=%b end=%b ovf=%b cmd=%b ba=%b addr=%h, expected req=%b end=%b ovf=%b cmd=%b ba=%b addr=%h",
                     name, a.req, a.end_p, a.ovf, a.cmd, a.ba, a.addr,
                     e.req, e.end_p, e.ovf, e.cmd, e.ba, e.addr);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    int         since   [NI];      // edges since the interval timer started
    bit         m_req   [NI];
    bit         m_ovf   [NI];
    logic [4:0] seq_buf [NI][64];  // {end, cmd} for every sequence cycle
    int         seq_len [NI];
    int         seq_pos [NI];      // seq_pos == seq_len means idle

    // Command list for one complete refresh sequence of instance i.
    task automatic build(int i);
        int n;
        n = 0;
        seq_buf[i][n] = {1'b0, PCH};
        n++;
        for (int t = 0; t < P_TRP[i]; t++) begin
            seq_buf[i][n] = {1'b0, NOP};
            n++;
        end
        for (int r = 0; r < P_NUM[i]; r++) begin
            seq_buf[i][n] = {1'b0, ARF};
            n++;
            for (int t = 0; t < P_TRFC[i]; t++) begin
                seq_buf[i][n] = {1'b0, NOP};
                n++;
            end
        end
        seq_buf[i][n] = {1'b1, NOP};
        n++;
        seq_len[i] = n;
        seq_pos[i] = 0;
    endtask

    function automatic logic ovf_exp(int i);
`ifdef DDR_AREF_OVF_EN
        return m_ovf[i];
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        obs_t e;
        logic en_s;
        bit   busy, term, start;
        for (int i = 0; i < NI; i++) begin
            if (!sys_rst_n) begin
                since[i]   = 0;
                m_req[i]   = 1'b0;
                m_ovf[i]   = 1'b0;
                seq_len[i] = 0;
                seq_pos[i] = 0;
                e = mk(1'b0, 1'b0, 1'b0, NOP);
            end else begin
                en_s  = (i == 0) ? en0 : en1;
                busy  = seq_pos[i] < seq_len[i];
                term  = init_end && ((since[i] % P_REF[i]) == P_REF[i] - 1);
                start = !busy && m_req[i] && en_s && init_end;
                if (term && (m_req[i] || busy)) m_ovf[i] = 1'b1;
                if (start)     m_req[i] = 1'b0;
                else if (term) m_req[i] = 1'b1;
                since[i] = init_end ? since[i] + 1 : 0;
                if (busy)  seq_pos[i]++;
                if (start) build(i);
                if (seq_pos[i] < seq_len[i])
                    e = mk(m_req[i], seq_buf[i][seq_pos[i]][4], ovf_exp(i),
                           seq_buf[i][seq_pos[i]][3:0]);
                else
                    e = mk(m_req[i], 1'b0, ovf_exp(i), NOP);
            end
            exp_q.push_back(e);
        end
    endtask

    initial begin
        forever begin
            @(posedge sys_clk);
            cyc++;
            model_step();
        end
    end

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    initial begin
        obs_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_empty inst%0d cyc%0d: no expected entry", i, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("inst%0d_cyc%0d", i, cyc), act(i), e);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    logic rp0 = 1'b0, rp1 = 1'b0;  // arbiter's view of req at the previous negedge

    task automatic step(mode_t m);
        @(negedge sys_clk);
        case (m)
            M_HOLD: begin
                en0 = 1'b0;
                en1 = 1'b0;
            end
            // Grant one cycle after the request is seen, then randomly keep
            // the grant asserted for a while (arbiter lag).
            M_ARB: begin
                en0 = rp0 | (en0 & ($urandom_range(0, 2) != 0));
                en1 = rp1 | (en1 & ($urandom_range(0, 2) != 0));
            end
            default: begin
                en0 = ($urandom_range(0, 3) == 0);
                en1 = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 399) == 0) init_end = ~init_end;
            end
        endcase
        rp0 = req0;
        rp1 = req1;
    endtask

    task automatic run(mode_t m, int n);
        for (int k = 0; k < n; k++) step(m);
    endtask

    task automatic wait_cmd(logic [3:0] c, string name);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            step(M_ARB);
            if (cmd0 === c) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: cmd %b not seen on inst0 within 4000 cycles", name, c);
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        init_end  = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Before initialization completes: no requests; random grants are ignored.
        run(M_RAND, 3000);
        init_end = 1'b0;

        // Initialization done, grant withheld: first request after REF_PERIOD.
        @(negedge sys_clk);
        init_end = 1'b1;
        run(M_HOLD, 1300);

        // Arbiter grants: full refresh sequences, lagging grant after the end pulse.
        run(M_ARB, 4000);

        // Grant withheld past the next interval: missed-interval case.
        run(M_HOLD, 2600);
        run(M_ARB, 200);

        // Reset during the 4th cycle of the first TRFC of a sequence.
        wait_cmd(PCH, "wait_pch");
        wait_cmd(ARF, "wait_ar");
        repeat (4) step(M_ARB);
        sys_rst_n = 1'b0;
        #1;
        check("rst_async_inst0", act(0), mk(1'b0, 1'b0, 1'b0, NOP));
        check("rst_async_inst1", act(1), mk(1'b0, 1'b0, 1'b0, NOP));
        repeat (2) @(negedge sys_clk);
        en0 = 1'b0;
        en1 = 1'b0;
        rp0 = 1'b0;
        rp1 = 1'b0;
        sys_rst_n = 1'b1;

        // Interval restarts after reset; sequences resume.
        run(M_ARB, 3000);

        // Random grants and occasional init_end toggles, including mid-sequence drops.
        run(M_RAND, 6000);
        @(negedge sys_clk);
        init_end = 1'b1;
        run(M_ARB, 500);

        @(negedge sys_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ddr_ctrl_aref.md
Name: ddr_ctrl_aref

Overview:
Auto-refresh sequencer for the SDRAM controller.
- Times the refresh interval and raises a refresh request toward the SDRAM arbiter.
- Once granted, drives the PRECHARGE-ALL / AUTO_REFRESH command sequence onto the arbiter's refresh command, bank and address inputs.
- Signals completion with a one-cycle end pulse.
- Sits between the init sequencer (gated by init_end) and the arbiter's AREF path.

Parameters:
- REF_PERIOD, 1250, refresh interval in sys_clk cycles (7.5 us at 167 MHz); legal >= 32
- TRP_CLK, 2, NOP cycles after PRECHARGE; legal 1..15
- TRFC_CLK, 7, NOP cycles after each AUTO_REFRESH; legal 1..15
- AREF_NUM, 2, AUTO_REFRESH commands per sequence; legal 1..4

Ports:
- sys_clk  in  1  system clock, 167 MHz
- sys_rst_n  in  1  reset
- init_end_i  in  1  SDRAM initialization done; level
- aref_en_i  in  1  refresh grant from arbiter; level
- aref_req_o  out  1  refresh request to arbiter
- aref_end_o  out  1  refresh sequence done; 1-cycle pulse
- aref_cmd_o  out  4  {cs_n,ras_n,cas_n,we_n}
- aref_ba_o  out  2  bank address
- aref_addr_o  out  13  address bus
- aref_ovf_o  out  1  sticky missed-interval flag; present only with DDR_AREF_OVF_EN

Behaviour:
Clock and reset:
- Reset sys_rst_n, asynchronous, active-low; clock sys_clk.
- Reset values: aref_req_o=0, aref_end_o=0, aref_cmd_o=4'b0111 (NOP), aref_ba_o=2'b11, aref_addr_o=13'h1fff, aref_ovf_o=0.
- Reset also sets: FSM=IDLE, all counters 0.
- Reset mid-sequence forces these values immediately; no partial command is completed.

Interval counter:
- Width $clog2(REF_PERIOD).
- Held at 0 while init_end_i=0; increments every cycle while init_end_i=1.
- Wraps from REF_PERIOD-1 to 0. Keeps running during a refresh sequence.
- At the edge where the counter equals REF_PERIOD-1, aref_req_o is set (registered).
- First request is therefore high exactly REF_PERIOD cycles after the first edge that samples init_end_i=1.

Request handshake:
- aref_req_o stays high until the FSM leaves IDLE, then clears on that same edge.
- A terminal count while aref_req_o is already high leaves it high; requests are not queued or counted.

Command encodings:
- NOP = 0111, PRECHARGE = 0010, AUTO_REFRESH = 0001.
- aref_ba_o=2'b11 and aref_addr_o=13'h1fff in all states; A10=1 selects all banks for PRECHARGE.
- aref_cmd_o and aref_end_o are Moore decodes of the registered state.

FSM states:
- IDLE: cmd NOP. Goes to PCH when aref_en_i=1. aref_en_i=1 while init_end_i=0 is ignored.
- PCH: cmd PRECHARGE for 1 cycle; go to TRP.
- TRP: cmd NOP for TRP_CLK cycles; go to AR.
- AR: cmd AUTO_REFRESH for 1 cycle; ar_cnt++; go to TRFC.
- TRFC: cmd NOP for TRFC_CLK cycles. Then go to END if ar_cnt==AREF_NUM, else back to AR.
- END: aref_end_o=1 and cmd NOP for 1 cycle; ar_cnt cleared; go to IDLE.

Timing and boundary rules:
- Sequence length = 2 + TRP_CLK + AREF_NUM*(1+TRFC_CLK) cycles; 20 with defaults.
- Wait counter is 4 bits and cleared on every state entry.
- aref_en_i deasserting mid-sequence is ignored; the sequence always completes.
- aref_en_i still high in the IDLE cycle right after END (arbiter lag) must not restart the sequence: a start requires aref_req_o=1 AND aref_en_i=1.
- init_end_i falling mid-sequence: the sequence completes, then the FSM holds in IDLE and the counter is held at 0.

Optional Feature:
DDR_AREF_OVF_EN
- Defined: aref_ovf_o port exists. It is set when the interval counter hits REF_PERIOD-1 while aref_req_o=1 or FSM!=IDLE (missed interval). Cleared only by reset.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
1. init_end_i=0 for 3000 cycles -> aref_req_o=0, aref_cmd_o=0111, aref_addr_o=1fff throughout.
2. init_end_i rises, aref_en_i held 0 -> aref_req_o rises exactly 1250 cycles after the first edge sampling init_end_i=1 and stays high.
3. Arbiter-model grant one cycle after the request -> aref_req_o drops on PCH entry. Command stream: 0010 x1, 0111 x2, 0001, 0111 x7, 0001, 0111 x7, then aref_end_o=1 for exactly 1 cycle; 20 cycles total; ba=11, addr=1fff throughout.
4. With DDR_AREF_OVF_EN, grant withheld 1300 cycles past the first request -> aref_ovf_o=1 at the second terminal count (cycle 2500); aref_req_o still high. After the grant, the normal 20-cycle sequence runs and aref_ovf_o stays 1.
5. sys_rst_n pulsed low during the 4th cycle of the first TRFC -> immediately cmd=0111, aref_end_o=0, aref_req_o=0. After release the interval restarts: next request 1250 cycles later.
6. AREF_NUM=1, TRFC_CLK=3, grant issued -> stream 0010, 0111 x2, 0001, 0111 x3, then end pulse; 8 cycles total.
